// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and sizing for the register-file writeback arbiter and its scoreboard.
package rf_pkg;

    localparam int REGISTER_WIDTH   = 64;
    localparam int REGISTERNO_WIDTH = 5;
    localparam int NUM_REGS         = 32;

    typedef logic [REGISTERNO_WIDTH-1:0] regno_t;
    typedef logic [REGISTER_WIDTH-1:0]   reg_value_t;

    typedef enum logic { WB_ALU, WB_MEM } wb_src_e;

    typedef enum logic [1:0] { ST_RUN, ST_DRAIN, ST_DONE } drain_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback, issue, hazard-query, register-file and drain signals of the arbiter.
interface regfile_wb_arbiter_if;
    import rf_pkg::*;

    logic       alu_valid;
    regno_t     alu_rd;
    reg_value_t alu_value;
    logic       alu_ready;

    logic       mem_valid;
    regno_t     mem_rd;
    reg_value_t mem_value;
    logic       mem_ready;

    logic       issue_valid;
    regno_t     issue_rd;
    logic       issue_ready;

    regno_t     query_rs1;
    regno_t     query_rs2;
    logic       rs1_busy;
    logic       rs2_busy;

    logic       wr_enable;
    regno_t     wr_regno;
    reg_value_t wr_value;

    logic       drain_req;
    logic       drain_done;

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_rd, alu_value,
        output alu_ready,
        input  mem_valid, mem_rd, mem_value,
        output mem_ready,
        input  issue_valid, issue_rd,
        output issue_ready,
        input  query_rs1, query_rs2,
        output rs1_busy, rs2_busy,
        output wr_enable, wr_regno, wr_value,
        input  drain_req,
        output drain_done
    );

    // Pipeline / environment side.
    modport master (
        output alu_valid, alu_rd, alu_value,
        input  alu_ready,
        output mem_valid, mem_rd, mem_value,
        input  mem_ready,
        output issue_valid, issue_rd,
        input  issue_ready,
        output query_rs1, query_rs2,
        input  rs1_busy, rs2_busy,
        input  wr_enable, wr_regno, wr_value,
        output drain_req,
        input  drain_done
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write bit per architectural register; x0 never pends, and a set beats a clear.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   set_en_i,
    input  regno_t set_idx_i,
    input  logic   clr_en_i,
    input  regno_t clr_idx_i,
    input  regno_t rs1_idx_i,
    input  regno_t rs2_idx_i,
    input  regno_t issue_idx_i,
    output logic   rs1_busy_o,
    output logic   rs2_busy_o,
    output logic   issue_busy_o,
    output logic   any_pending_o
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pending_d = pending_q;
        if (clr_en_i) pending_d[clr_idx_i] = 1'b0;
        if (set_en_i) pending_d[set_idx_i] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // NOTE: the pending vector is plain flops, so it takes the async reset like any other state.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    assign rs1_busy_o    = (rs1_idx_i   != '0) && pending_q[rs1_idx_i];
    assign rs2_busy_o    = (rs2_idx_i   != '0) && pending_q[rs2_idx_i];
    assign issue_busy_o  = (issue_idx_i != '0) && pending_q[issue_idx_i];
    assign any_pending_o = |pending_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin owner of the register-file write port, with hazard scoreboard and drain sequencer.
module regfile_wb_arbiter
    import rf_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    regfile_wb_arbiter_if.slave bus
);

    wb_src_e      rr_last_q, rr_last_d;
    drain_state_e state_q, state_d;
    logic         wr_enable_q, wr_enable_d;
    regno_t       wr_regno_q, wr_regno_d;
    reg_value_t   wr_value_q, wr_value_d;

    logic       grant_alu, grant_mem, grant;
    regno_t     grant_rd;
    reg_value_t grant_value;
    logic       issue_busy, any_pending, issue_ready, set_en, quiet;

    // On a tie the source that did not win last time is granted.
    always_comb begin
        grant_alu   = bus.alu_valid && (!bus.mem_valid || rr_last_q == WB_MEM);
        grant_mem   = bus.mem_valid && !grant_alu;
        grant       = grant_alu || grant_mem;
        grant_rd    = grant_mem ? bus.mem_rd    : bus.alu_rd;
        grant_value = grant_mem ? bus.mem_value : bus.alu_value;

        rr_last_d = rr_last_q;
        if (grant_alu)      rr_last_d = WB_ALU;
        else if (grant_mem) rr_last_d = WB_MEM;

        wr_enable_d = grant && (grant_rd != '0);
        wr_regno_d  = grant ? grant_rd    : wr_regno_q;
        wr_value_d  = grant ? grant_value : wr_value_q;
    end

    always_comb begin
        state_d     = state_q;
        quiet       = !any_pending && !wr_enable_q && !bus.alu_valid && !bus.mem_valid;
        issue_ready = (state_q == ST_RUN) && !issue_busy;
        unique case (state_q)
            ST_RUN:   if (bus.drain_req) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!bus.drain_req) state_d = ST_RUN;
                else if (quiet)     state_d = ST_DONE;
            end
            ST_DONE:  if (!bus.drain_req) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    assign set_en = bus.issue_valid && issue_ready && (bus.issue_rd != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_last_q   <= WB_MEM;
            state_q     <= ST_RUN;
            wr_enable_q <= 1'b0;
            wr_regno_q  <= '0;
            wr_value_q  <= '0;
        end else begin
            rr_last_q   <= rr_last_d;
            state_q     <= state_d;
            wr_enable_q <= wr_enable_d;
            wr_regno_q  <= wr_regno_d;
            wr_value_q  <= wr_value_d;
        end
    end

    rf_scoreboard u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .set_en_i      (set_en),
        .set_idx_i     (bus.issue_rd),
        .clr_en_i      (wr_enable_q),
        .clr_idx_i     (wr_regno_q),
        .rs1_idx_i     (bus.query_rs1),
        .rs2_idx_i     (bus.query_rs2),
        .issue_idx_i   (bus.issue_rd),
        .rs1_busy_o    (bus.rs1_busy),
        .rs2_busy_o    (bus.rs2_busy),
        .issue_busy_o  (issue_busy),
        .any_pending_o (any_pending)
    );

    assign bus.alu_ready   = grant_alu;
    assign bus.mem_ready   = grant_mem;
    assign bus.issue_ready = issue_ready;
    assign bus.wr_enable   = wr_enable_q;
    assign bus.wr_regno    = wr_regno_q;
    assign bus.wr_value    = wr_value_q;
    assign bus.drain_done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration, write timing, scoreboard, drain and async reset.
module tb_regfile_wb_arbiter;
    import rf_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.alu_valid   = 1'b0; bus.alu_rd = '0; bus.alu_value = '0;
        bus.mem_valid   = 1'b0; bus.mem_rd = '0; bus.mem_value = '0;
        bus.issue_valid = 1'b0; bus.issue_rd = '0;
        bus.query_rs1   = '0;   bus.query_rs2 = '0;
        bus.drain_req   = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clear_inputs();
        reset = 1'b0;
        #12;
        check("rst_wr_enable",  64'(bus.wr_enable),   64'd0);
        check("rst_wr_regno",   64'(bus.wr_regno),    64'd0);
        check("rst_wr_value",   64'(bus.wr_value),    64'd0);
        check("rst_drain_done", 64'(bus.drain_done),  64'd0);
        check("rst_issue_rdy",  64'(bus.issue_ready), 64'd1);
        check("rst_alu_ready",  64'(bus.alu_ready),   64'd0);
        do_reset();

        // Single ALU writeback: accepted now, written the following cycle only.
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_value = 64'd42;
        #1;
        check("t1_alu_ready", 64'(bus.alu_ready), 64'd1);
        check("t1_mem_ready", 64'(bus.mem_ready), 64'd0);
        check("t1_wr_pre",    64'(bus.wr_enable), 64'd0);
        step(); bus.alu_valid = 1'b0; #1;
        check("t1_wr_enable", 64'(bus.wr_enable), 64'd1);
        check("t1_wr_regno",  64'(bus.wr_regno),  64'd5);
        check("t1_wr_value",  64'(bus.wr_value),  64'd42);
        step();
        check("t1_wr_off",    64'(bus.wr_enable), 64'd0);

        // Tie after reset: ALU first, then MEM on the next cycle.
        do_reset();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_value = 64'd7;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd4; bus.mem_value = 64'd9;
        #1;
        check("t2_alu_ready", 64'(bus.alu_ready), 64'd1);
        check("t2_mem_wait",  64'(bus.mem_ready), 64'd0);
        step(); bus.alu_valid = 1'b0; #1;
        check("t2_mem_ready", 64'(bus.mem_ready), 64'd1);
        check("t2_wr0_regno", 64'(bus.wr_regno),  64'd3);
        check("t2_wr0_value", 64'(bus.wr_value),  64'd7);
        step(); bus.mem_valid = 1'b0; #1;
        check("t2_wr1_en",    64'(bus.wr_enable), 64'd1);
        check("t2_wr1_regno", 64'(bus.wr_regno),  64'd4);
        check("t2_wr1_value", 64'(bus.wr_value),  64'd9);

        // After an ALU win, a tie goes to MEM.
        step();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_value = 64'd1;
        step();
        bus.alu_rd = 5'd2; bus.alu_value = 64'd2;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd6; bus.mem_value = 64'd6;
        #1;
        check("t2b_mem_first", 64'(bus.mem_ready), 64'd1);
        check("t2b_alu_wait",  64'(bus.alu_ready), 64'd0);
        step(); bus.mem_valid = 1'b0; #1;
        check("t2b_alu_next",  64'(bus.alu_ready), 64'd1);
        check("t2b_wr_regno",  64'(bus.wr_regno),  64'd6);
        step(); bus.alu_valid = 1'b0; #1;
        check("t2b_wr2_regno", 64'(bus.wr_regno),  64'd2);
        check("t2b_wr2_value", 64'(bus.wr_value),  64'd2);
        step();

        // RAW hazard on x8, cleared by a load writeback.
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd8;
        #1;
        check("t3_issue_ok", 64'(bus.issue_ready), 64'd1);
        step(); bus.issue_valid = 1'b0; bus.query_rs1 = 5'd8; bus.query_rs2 = 5'd8; #1;
        check("t3_rs1_busy",  64'(bus.rs1_busy),    64'd1);
        check("t3_rs2_busy",  64'(bus.rs2_busy),    64'd1);
        check("t3_waw_stall", 64'(bus.issue_ready), 64'd0);
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd8; bus.mem_value = 64'h55;
        #1;
        check("t3_mem_ready", 64'(bus.mem_ready), 64'd1);
        step(); bus.mem_valid = 1'b0; #1;
        check("t3_wr_en",      64'(bus.wr_enable), 64'd1);
        check("t3_wr_regno",   64'(bus.wr_regno),  64'd8);
        check("t3_busy_hold",  64'(bus.rs1_busy),  64'd1);
        step();
        check("t3_busy_clear", 64'(bus.rs1_busy),    64'd0);
        check("t3_issue_back", 64'(bus.issue_ready), 64'd1);

        // Writes to x0 are accepted but never reach the register file.
        bus.issue_rd = 5'd0; bus.query_rs1 = 5'd0; bus.query_rs2 = 5'd0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_value = 64'd99;
        #1;
        check("t4_alu_ready", 64'(bus.alu_ready), 64'd1);
        step(); bus.alu_valid = 1'b0; #1;
        check("t4_no_write",  64'(bus.wr_enable), 64'd0);
        check("t4_x0_busy",   64'(bus.rs1_busy),  64'd0);
        bus.issue_valid = 1'b1; #1;
        check("t4_issue_x0",  64'(bus.issue_ready), 64'd1);
        step(); bus.issue_valid = 1'b0; #1;
        check("t4_x0_still",  64'(bus.rs2_busy),  64'd0);

        // Set and clear of the same register at one edge: set wins.
        bus.query_rs1 = 5'd11;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd11; bus.alu_value = 64'd11;
        #1;
        check("t5_pre_busy", 64'(bus.rs1_busy), 64'd0);
        step(); bus.alu_valid = 1'b0; bus.issue_valid = 1'b1; bus.issue_rd = 5'd11; #1;
        check("t5_wr_regno", 64'(bus.wr_regno),    64'd11);
        check("t5_issue_ok", 64'(bus.issue_ready), 64'd1);
        step(); bus.issue_valid = 1'b0; bus.issue_rd = 5'd0; #1;
        check("t5_set_wins", 64'(bus.rs1_busy), 64'd1);
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd11; bus.mem_value = 64'd0;
        step(); bus.mem_valid = 1'b0;
        step();
        check("t5_cleared",  64'(bus.rs1_busy), 64'd0);

        // Drain waits for the outstanding x10 writeback.
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd10;
        step(); bus.issue_valid = 1'b0; bus.issue_rd = 5'd0; bus.drain_req = 1'b1; #1;
        check("t6_run_issue",  64'(bus.issue_ready), 64'd1);
        step();
        check("t6_drain_stall", 64'(bus.issue_ready), 64'd0);
        check("t6_not_done0",   64'(bus.drain_done),  64'd0);
        step();
        check("t6_not_done1",   64'(bus.drain_done),  64'd0);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_value = 64'h1234;
        #1;
        check("t6_alu_ready",   64'(bus.alu_ready),   64'd1);
        step(); bus.alu_valid = 1'b0; #1;
        check("t6_wr_en",       64'(bus.wr_enable),   64'd1);
        check("t6_not_done2",   64'(bus.drain_done),  64'd0);
        step();
        check("t6_not_done3",   64'(bus.drain_done),  64'd0);
        step();
        check("t6_done",        64'(bus.drain_done),  64'd1);
        check("t6_done_stall",  64'(bus.issue_ready), 64'd0);
        bus.drain_req = 1'b0; #1;
        check("t6_done_hold",   64'(bus.drain_done),  64'd1);
        step();
        check("t6_done_drop",   64'(bus.drain_done),  64'd0);
        check("t6_issue_back",  64'(bus.issue_ready), 64'd1);

        // Drain abandoned before completion goes straight back to RUN.
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd13;
        step(); bus.issue_valid = 1'b0; bus.issue_rd = 5'd0; bus.drain_req = 1'b1;
        step();
        check("t7_drain_stall", 64'(bus.issue_ready), 64'd0);
        bus.drain_req = 1'b0;
        step();
        check("t7_abort_run",   64'(bus.issue_ready), 64'd1);
        check("t7_abort_done",  64'(bus.drain_done),  64'd0);

        // Async reset mid-cycle drops the in-flight write and the scoreboard.
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd12;
        step(); bus.issue_valid = 1'b0; bus.issue_rd = 5'd0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd14; bus.alu_value = 64'd7;
        step(); bus.alu_valid = 1'b0; bus.query_rs1 = 5'd12; bus.query_rs2 = 5'd13; #1;
        check("t8_wr_en_pre", 64'(bus.wr_enable), 64'd1);
        check("t8_busy_pre",  64'(bus.rs1_busy),  64'd1);
        reset = 1'b0; #1;
        check("t8_wr_en",     64'(bus.wr_enable),  64'd0);
        check("t8_wr_regno",  64'(bus.wr_regno),   64'd0);
        check("t8_rs1_busy",  64'(bus.rs1_busy),   64'd0);
        check("t8_rs2_busy",  64'(bus.rs2_busy),   64'd0);
        check("t8_drain",     64'(bus.drain_done), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        check("t8_post_wr",   64'(bus.wr_enable),  64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Owns the single write port of the 32-entry integer register file. It arbitrates between two writeback requesters, the ALU path and the load/memory path, using round-robin. It keeps a pending-write scoreboard so the issue stage can stall on RAW/WAW hazards. It also runs a drain sequence that quiesces all writebacks before the register dump/finish request is honoured.

Parameters:
REGISTER_WIDTH, 64, data width of a register
REGISTERNO_WIDTH, 5, register index width
NUM_REGS, 32, number of architectural registers (x0 hardwired zero)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low (0 = in reset)
alu_valid  input  1  ALU writeback request
alu_rd  input  REGISTERNO_WIDTH  ALU destination
alu_value  input  REGISTER_WIDTH  ALU result
alu_ready  output  1  ALU request accepted this cycle
mem_valid  input  1  load writeback request
mem_rd  input  REGISTERNO_WIDTH  load destination
mem_value  input  REGISTER_WIDTH  load data
mem_ready  output  1  load request accepted this cycle
issue_valid  input  1  issue stage dispatching an instruction with a destination
issue_rd  input  REGISTERNO_WIDTH  its destination
issue_ready  output  1  dispatch may proceed
query_rs1  input  REGISTERNO_WIDTH  source 1 hazard query
query_rs2  input  REGISTERNO_WIDTH  source 2 hazard query
rs1_busy  output  1  query_rs1 has a pending write
rs2_busy  output  1  query_rs2 has a pending write
wr_enable  output  1  to register file write enable
wr_regno  output  REGISTERNO_WIDTH  to register file destination
wr_value  output  REGISTER_WIDTH  to register file data
drain_req  input  1  request to quiesce (level)
drain_done  output  1  quiescent, register dump may proceed

Behaviour:
- Reset (reset==0, async): pending[] = 0, wr_enable = 0, wr_regno = 0, wr_value = 0, rr_last = MEM (ALU wins the first tie), state = RUN, drain_done = 0. Reset mid-operation drops any in-flight write; nothing is written.
- Arbitration (combinational): if only one requester is valid, it is granted. If both are valid, grant the one not equal to rr_last. rr_last updates to the granted source on every grant. alu_ready/mem_ready = grant to that requester, zero if neither is valid. A requester holds valid/rd/value stable until ready.
- Write port: a grant at edge N registers rd/value. wr_enable = 1 for exactly the cycle between edges N and N+1, when the register file performs the write. If the granted rd == 0, the request is still accepted (ready = 1) but wr_enable stays 0. No back-pressure from the register file; throughput is one write per cycle.
- Scoreboard: pending[NUM_REGS] bit vector; pending[0] is always 0.
  - issue_ready = (state == RUN) && (issue_rd == 0 || !pending[issue_rd]).
  - On issue_valid && issue_ready with issue_rd != 0, set pending[issue_rd] at the next edge.
  - On a wr_enable cycle, clear pending[wr_regno] at the edge that ends it. The value is therefore in the register file when busy drops.
  - Same register set and cleared at the same edge: set wins.
  - Writeback to a register that is not pending is legal: it is written and the scoreboard is unchanged.
- Busy queries are combinational: rsN_busy = pending[query_rsN], forced 0 for index 0.
- FSM:
  - RUN → DRAIN when drain_req = 1.
  - DRAIN: issue_ready = 0; writeback arbitration continues. DRAIN → DONE when pending == 0 && !wr_enable && !alu_valid && !mem_valid.
  - DONE: drain_done = 1 (registered), issue_ready = 0. DONE → RUN when drain_req = 0; drain_done returns to 0 on that edge.
  - drain_req dropped while in DRAIN → RUN.

Decomposition:
- Shared package rf_pkg: REGISTER_WIDTH/REGISTERNO_WIDTH/NUM_REGS constants, typedef regno_t, typedef wb_src_e {WB_ALU, WB_MEM}, typedef drain_state_e {ST_RUN, ST_DRAIN, ST_DONE}.
- One sub-module, rf_scoreboard: pending vector, set/clear with set-wins rule, two combinational busy ports plus the issue lookup, any_pending output.
- Arbitration, output registers and FSM stay in the top.

Test Plan:
- Release reset, alu_valid with rd=5, value=42 → alu_ready=1 same cycle; next cycle wr_enable=1, wr_regno=5, wr_value=42; following cycle wr_enable=0.
- alu (rd=3, 7) and mem (rd=4, 9) both held valid after reset → ALU granted first, then MEM. Writes on consecutive cycles: (3,7) then (4,9).
- issue rd=8 → next cycle rs1_busy=1 with query_rs1=8, and issue rd=8 gives issue_ready=0. mem writes rd=8 → busy drops at the edge ending the wr_enable cycle, and issue_ready returns to 1.
- alu rd=0, value=99 → alu_ready=1, wr_enable never asserts; query_rs1=0 → rs1_busy=0; issue rd=0 does not set pending.
- Issue rd=10, then drain_req=1 → issue_ready=0, drain_done stays 0 until the rd=10 writeback completes, then drain_done=1. Drop drain_req → drain_done=0 and issue_ready=1 next cycle.
- Pend rd=12, pull reset low asynchronously mid-cycle → pending cleared, wr_enable=0 and drain_done=0 immediately, with no clock edge required.
